// File: rtl/iqft4_serial.sv
// rtl/iqft4_serial.sv - serial 4-point inverse QFT engine (load, calc, send)
module iqft4_serial #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  s_re,
  input  logic signed [IN_W-1:0]  s_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] m_re,
  output logic signed [OUT_W-1:0] m_im,
  output logic [1:0]              m_idx,
  output logic                    m_last,
  output logic                    m_sat,
  output logic                    busy
);

  typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

  // Four terms of IN_W bits each fit in IN_W+2 bits, so the sums cannot overflow.
  localparam int SUM_W = IN_W + 2;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-(2 ** (OUT_W - 1)));

  state_t                  state;
  logic [1:0]              cnt;
  logic signed [IN_W-1:0]  smp_re [4];
  logic signed [IN_W-1:0]  smp_im [4];
  logic signed [OUT_W-1:0] res_re [4];
  logic signed [OUT_W-1:0] res_im [4];
  logic [3:0]              res_sat;

  logic signed [SUM_W-1:0] r0, r1, r2, r3, i0, i1, i2, i3;
  logic signed [SUM_W-1:0] sum_re, sum_im, norm_re, norm_im;
  logic signed [OUT_W-1:0] clip_re, clip_im;
  logic                    sat_re, sat_im;

  // Conjugate-twiddle butterfly for output n = cnt, then floor /4 and clip.
  always_comb begin
    r0 = SUM_W'(smp_re[0]);
    r1 = SUM_W'(smp_re[1]);
    r2 = SUM_W'(smp_re[2]);
    r3 = SUM_W'(smp_re[3]);
    i0 = SUM_W'(smp_im[0]);
    i1 = SUM_W'(smp_im[1]);
    i2 = SUM_W'(smp_im[2]);
    i3 = SUM_W'(smp_im[3]);
    sum_re = '0;
    sum_im = '0;
    case (cnt)
      2'd0: begin
        sum_re = r0 + r1 + r2 + r3;
        sum_im = i0 + i1 + i2 + i3;
      end
      2'd1: begin
        sum_re = r0 - i1 - r2 + i3;
        sum_im = i0 + r1 - i2 - r3;
      end
      2'd2: begin
        sum_re = r0 - r1 + r2 - r3;
        sum_im = i0 - i1 + i2 - i3;
      end
      default: begin
        sum_re = r0 + i1 - r2 - i3;
        sum_im = i0 - r1 - i2 + r3;
      end
    endcase
    norm_re = sum_re >>> 2;
    norm_im = sum_im >>> 2;
    sat_re  = 1'b0;
    sat_im  = 1'b0;
    clip_re = OUT_W'(norm_re);
    clip_im = OUT_W'(norm_im);
    if (norm_re > MAX_V) begin
      clip_re = OUT_W'(MAX_V);
      sat_re  = 1'b1;
    end else if (norm_re < MIN_V) begin
      clip_re = OUT_W'(MIN_V);
      sat_re  = 1'b1;
    end
    if (norm_im > MAX_V) begin
      clip_im = OUT_W'(MAX_V);
      sat_im  = 1'b1;
    end else if (norm_im < MIN_V) begin
      clip_im = OUT_W'(MIN_V);
      sat_im  = 1'b1;
    end
  end

  // Frame FSM with all stream outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      cnt     <= 2'd0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_idx   <= 2'd0;
      m_last  <= 1'b0;
      m_sat   <= 1'b0;
      busy    <= 1'b0;
      res_sat <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        smp_re[k] <= '0;
        smp_im[k] <= '0;
        res_re[k] <= '0;
        res_im[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (s_valid) begin
            smp_re[cnt] <= s_re;
            smp_im[cnt] <= s_im;
            cnt         <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              state   <= CALC;
              s_ready <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          res_re[cnt]  <= clip_re;
          res_im[cnt]  <= clip_im;
          res_sat[cnt] <= sat_re | sat_im;
          cnt          <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // result[0] was written three cycles ago, so it can be presented now.
            state   <= SEND;
            m_valid <= 1'b1;
            m_idx   <= 2'd0;
            m_re    <= res_re[0];
            m_im    <= res_im[0];
            m_sat   <= res_sat[0];
            m_last  <= 1'b0;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (m_idx == 2'd3) begin
              state   <= LOAD;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              m_idx   <= 2'd0;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end else begin
              m_idx  <= m_idx + 2'd1;
              m_re   <= res_re[m_idx + 2'd1];
              m_im   <= res_im[m_idx + 2'd1];
              m_sat  <= res_sat[m_idx + 2'd1];
              m_last <= (m_idx == 2'd2);
            end
          end
        end
        default: begin
          state   <= LOAD;
          cnt     <= 2'd0;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
